point4_sample_framer: RTL

- Upstream stage of the 4-point FFT.
- Accepts a serial stream of signed N-bit samples over a valid/ready handshake.
- Groups them into 4-sample frames in a ping-pong (two-bank) register buffer.
- Presents each complete frame in parallel on f_0..f_3 with a frame-level valid/ready handshake.
- Sustains one sample per clock while the FFT drains one frame per four clocks.

---
 rtl/point4_pkg.sv | 17 +
 rtl/point4_sample_bank.sv | 23 ++
 rtl/point4_sample_framer.sv | 86 ++++++++
 3 files changed

// File: rtl/point4_pkg.sv
// Shared constants and index helpers for the 4-point FFT front end.
package point4_pkg;

    localparam int SAMPLE_W  = 8;
    localparam int FRAME_LEN = 4;
    localparam int IDX_W     = 2;

    function automatic logic [IDX_W-1:0] bit_rev(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = 0; i < IDX_W; i++) begin
            res[i] = idx[IDX_W-1-i];
        end
        return res;
    endfunction

endpackage

// File: rtl/point4_sample_bank.sv
// One frame's worth of sample registers, written one entry at a time.
module point4_sample_bank
    import point4_pkg::*;
#(
    parameter int N = SAMPLE_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [IDX_W-1:0]              widx,
    input  logic [N-1:0]                  wdata,
    output logic [FRAME_LEN-1:0][N-1:0]   entries
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
        end else if (we) begin
            entries[widx] <= wdata;
        end
    end

endmodule

// File: rtl/point4_sample_framer.sv
// Serial-to-frame ping-pong buffer feeding the 4-point FFT.
// Define POINT4_BITREV_EN to present frames in bit-reversed order.
module point4_sample_framer
    import point4_pkg::*;
#(
    parameter int N = SAMPLE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [N-1:0] f_0,
    output logic [N-1:0] f_1,
    output logic [N-1:0] f_2,
    output logic [N-1:0] f_3,
    output logic         frame_valid,
    input  logic         frame_ready
);

    logic [1:0]                  bank_full;
    logic                        wr_bank;
    logic                        rd_bank;
    logic [IDX_W-1:0]            wr_idx;
    logic [FRAME_LEN-1:0][N-1:0] bank_q [2];
    logic [FRAME_LEN-1:0][N-1:0] rd_frame;
    logic [FRAME_LEN-1:0][N-1:0] out_frame;
    logic                        accept;
    logic                        consume;

    assign s_ready     = ~bank_full[wr_bank];
    assign frame_valid = bank_full[rd_bank];
    assign accept      = s_valid & s_ready;
    assign consume     = frame_valid & frame_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        point4_sample_bank #(.N(N)) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (accept && (wr_bank == 1'(b))),
            .widx    (wr_idx),
            .wdata   (s_data),
            .entries (bank_q[b])
        );
    end

    // Fill and consume never hit the same bank, so both may update bank_full together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
        end else begin
            if (accept) begin
                wr_idx <= wr_idx + 1'b1;
                if (wr_idx == IDX_W'(FRAME_LEN - 1)) begin
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= ~wr_bank;
                end
            end
            if (consume) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
        end
    end

    always_comb begin
        rd_frame  = bank_q[rd_bank];
        out_frame = '0;
        for (int k = 0; k < FRAME_LEN; k++) begin
`ifdef POINT4_BITREV_EN
            out_frame[k] = rd_frame[bit_rev(IDX_W'(k))];
`else
            out_frame[k] = rd_frame[k];
`endif
        end
    end

    assign f_0 = out_frame[0];
    assign f_1 = out_frame[1];
    assign f_2 = out_frame[2];
    assign f_3 = out_frame[3];

endmodule
